// File: rtl/key_search_pkg.sv
// Shared state encoding and plaintext character class for the RC4 key-search checker.
package key_search_pkg;

    localparam int DEF_MSG_LEN   = 32'sd32;
    localparam int DEF_KEY_WIDTH = 32'sd22;

    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_RUN  = 3'd2,
        ST_RD_ADDR   = 3'd3,
        ST_RD_WAIT   = 3'd4,
        ST_CHECK     = 3'd5,
        ST_FOUND     = 3'd6,
        ST_EXHAUSTED = 3'd7
    } search_state_t;

    // Lowercase ASCII letters and the space character are the only acceptable plaintext.
    function automatic logic is_plain_char(input logic [7:0] c);
        return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SPACE);
    endfunction

endpackage

// File: rtl/key_search_checker.sv
// Key-sweep controller: launches each candidate key through the decrypt chain and
// scans the decrypted message until a fully plaintext result or the range ends.
module key_search_checker
    import key_search_pkg::*;
#(
    parameter int                   MSG_LEN   = DEF_MSG_LEN,
    parameter int                   KEY_WIDTH = DEF_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_FIRST = {KEY_WIDTH{1'b0}},
    parameter logic [KEY_WIDTH-1:0] KEY_LAST  = {KEY_WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 search_start,
    input  logic                 search_abort,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 run_key,
    input  logic                 run_done,
    output logic [7:0]           msg_address,
    input  logic [7:0]           msg_q,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic [4:0]           fail_index
);

    localparam int IDX_W = (MSG_LEN > 32'sd1) ? $clog2(MSG_LEN) : 32'sd1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 32'sd1);

    search_state_t        state_r;
    logic [KEY_WIDTH-1:0] key_r;
    logic [IDX_W-1:0]     k_r;
    logic                 run_key_r;
    logic                 busy_r;
    logic                 found_r;
    logic                 exhausted_r;
    logic [4:0]           fail_index_r;
    logic [7:0]           msg_address_s;

    // Sweep FSM with key register, byte counter and all registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            key_r        <= {KEY_WIDTH{1'b0}};
            k_r          <= {IDX_W{1'b0}};
            run_key_r    <= 1'b0;
            busy_r       <= 1'b0;
            found_r      <= 1'b0;
            exhausted_r  <= 1'b0;
            fail_index_r <= 5'd0;
        end else if (search_abort) begin
            // Abort wins over start and run_done; the key is kept for inspection.
            state_r     <= ST_IDLE;
            run_key_r   <= 1'b0;
            busy_r      <= 1'b0;
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
        end else begin
            run_key_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                    if (search_start) begin
                        key_r        <= KEY_FIRST;
                        found_r      <= 1'b0;
                        exhausted_r  <= 1'b0;
                        fail_index_r <= 5'd0;
                        run_key_r    <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state_r <= ST_WAIT_RUN;
                end
                ST_WAIT_RUN: begin
                    if (run_done) begin
                        k_r     <= {IDX_W{1'b0}};
                        state_r <= ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    state_r <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state_r <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (is_plain_char(msg_q)) begin
                        if (k_r == LAST_IDX) begin
                            found_r <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_FOUND;
                        end else begin
                            k_r     <= k_r + IDX_W'(1'b1);
                            state_r <= ST_RD_ADDR;
                        end
                    end else begin
                        fail_index_r <= 5'(k_r);
                        // Testing KEY_LAST before incrementing keeps the key from wrapping.
                        if (key_r == KEY_LAST) begin
                            exhausted_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= ST_EXHAUSTED;
                        end else begin
                            key_r     <= key_r + KEY_WIDTH'(1'b1);
                            run_key_r <= 1'b1;
                            state_r   <= ST_LAUNCH;
                        end
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM address is only driven while this block owns the decrypted-message port.
    always_comb begin
        msg_address_s = 8'h00;
        if ((state_r == ST_RD_ADDR) || (state_r == ST_RD_WAIT) || (state_r == ST_CHECK)) begin
            msg_address_s = 8'(k_r);
        end else begin
            msg_address_s = 8'h00;
        end
    end

    assign key         = key_r;
    assign run_key     = run_key_r;
    assign busy        = busy_r;
    assign found       = found_r;
    assign exhausted   = exhausted_r;
    assign fail_index  = fail_index_r;
    assign msg_address = msg_address_s;

endmodule

// File: tb/tb_key_search_checker.sv
// Self-checking bench: a transaction-level timeline model predicts every output per cycle.
module tb_key_search_checker;

    localparam int NEVER = 32'h3FFF_FFFF;
    localparam int F_KEY = 0, F_RK = 1, F_BUSY = 2, F_FOUND = 3, F_EXH = 4, F_FAIL = 5, F_ADDR = 6;

    typedef struct { int f; int v; int at; } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        search_start = 1'b0, search_abort = 1'b0, run_done = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  msg_q;
    logic [7:0]  ram [0:255];

    logic [21:0] key_a, key_b;
    logic        rk_a, rk_b, busy_a, busy_b, found_a, found_b, exh_a, exh_b;
    logic [7:0]  addr_a, addr_b;
    logic [4:0]  fail_a, fail_b;
    logic        start_a, start_b;

    logic [21:0] key_s;
    logic        rk_s, busy_s, found_s, exh_s;
    logic [7:0]  addr_s;
    logic [4:0]  fail_s;

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    int expv [0:6];
    ev_t evq [$];
    int scn = 0;
    logic [7:0] acc_char = 8'h61;

    int m_key = 0, m_active = 0, m_wait = 0, m_wait_from = 0, done_at = NEVER, m_end = NEVER;
    int rd_cycles [$];
    int rk_cycles [$];
    int rk_count = 0, found_cyc = -1, exh_cyc = -1;

    always #5 clk = ~clk;

    assign start_a = search_start & ~sel;
    assign start_b = search_start & sel;
    assign key_s   = sel ? key_b   : key_a;
    assign rk_s    = sel ? rk_b    : rk_a;
    assign busy_s  = sel ? busy_b  : busy_a;
    assign found_s = sel ? found_b : found_a;
    assign exh_s   = sel ? exh_b   : exh_a;
    assign addr_s  = sel ? addr_b  : addr_a;
    assign fail_s  = sel ? fail_b  : fail_a;

    key_search_checker dut_a (
        .clk(clk), .reset(reset), .search_start(start_a), .search_abort(search_abort),
        .key(key_a), .run_key(rk_a), .run_done(run_done), .msg_address(addr_a), .msg_q(msg_q),
        .busy(busy_a), .found(found_a), .exhausted(exh_a), .fail_index(fail_a)
    );

    key_search_checker #(.KEY_FIRST(22'd10), .KEY_LAST(22'd12)) dut_b (
        .clk(clk), .reset(reset), .search_start(start_b), .search_abort(search_abort),
        .key(key_b), .run_key(rk_b), .run_done(run_done), .msg_address(addr_b), .msg_q(msg_q),
        .busy(busy_b), .found(found_b), .exhausted(exh_b), .fail_index(fail_b)
    );

    // Synchronous-read decrypted-message RAM shared by whichever instance is active.
    always @(posedge clk) msg_q <= ram[addr_s];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic plain(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
    endfunction

    function automatic logic [7:0] content(input int k, input int idx);
        string msg;
        logic [7:0] base;
        msg = "attack at dawn";
        base = (idx < msg.len()) ? msg[idx] : 8'h20;
        case (scn)
            1: return (k <= 2 && idx == 5) ? 8'h41 : base;
            2: return (idx == 0) ? 8'h00 : 8'h61;
            3: begin
                if (idx != 31) return 8'h61;
                else if (k == 0) return 8'h60;
                else if (k == 1) return 8'h7B;
                else return acc_char;
            end
            default: return base;
        endcase
    endfunction

    task automatic ev(input int f, input int v, input int at);
        evq.push_back('{f, v, at});
    endtask

    task automatic model_reset();
        evq.delete();
        for (int i = 0; i < 7; i++) expv[i] = 0;
        m_active = 0; m_wait = 0; done_at = NEVER; m_end = NEVER;
    endtask

    task automatic launch(input int l);
        ev(F_RK, 1, l);
        ev(F_RK, 0, l + 1);
        m_wait = 1; m_wait_from = l + 1; done_at = l + 10;
    endtask

    // Model: what the outputs must do, in terms of the cycle each input was applied.
    task automatic model_cycle(input logic st, input logic ab, input logic rd);
        int c, f, t, first, last;
        ev_t keep [$];
        c = cyc;
        first = sel ? 10 : 0;
        last  = sel ? 12 : 22'h3FFFFF;
        if (!reset) begin
            model_reset();
        end else if (ab) begin
            foreach (evq[i]) if (evq[i].at <= c) keep.push_back(evq[i]);
            evq = keep;
            ev(F_FOUND, 0, c + 1); ev(F_EXH, 0, c + 1); ev(F_BUSY, 0, c + 1);
            ev(F_RK, 0, c + 1); ev(F_ADDR, -1, c + 1);
            m_active = 0; m_wait = 0; done_at = NEVER; m_end = NEVER;
        end else if (st && !(m_active != 0 && c < m_end)) begin
            m_active = 1; m_end = NEVER; m_key = first;
            ev(F_KEY, first, c + 1); ev(F_FOUND, 0, c + 1); ev(F_EXH, 0, c + 1);
            ev(F_FAIL, 0, c + 1); ev(F_BUSY, 1, c + 1);
            launch(c + 1);
        end else if (rd && m_wait != 0 && c >= m_wait_from) begin
            m_wait = 0; done_at = NEVER;
            rd_cycles.push_back(c);
            for (int i = 0; i < 32; i++) ram[i] = content(m_key, i);
            f = 32;
            for (int i = 31; i >= 0; i--) if (!plain(ram[i])) f = i;
            for (int k = 0; k <= ((f == 32) ? 31 : f); k++) begin
                ev(F_ADDR, k, c + 3 * k + 1);
                ev(F_ADDR, -1, c + 3 * k + 3);
            end
            if (f == 32) begin
                m_end = c + 97;
                ev(F_FOUND, 1, m_end); ev(F_BUSY, 0, m_end);
            end else begin
                t = c + 3 * f + 4;
                ev(F_FAIL, f, t);
                if (m_key == last) begin
                    m_end = t;
                    ev(F_EXH, 1, t); ev(F_BUSY, 0, t);
                end else begin
                    m_key++;
                    ev(F_KEY, m_key, t);
                    launch(t);
                end
            end
        end
    endtask

    // Per-cycle compare of every output against the model, plus an event log for literal checks.
    always @(negedge clk) begin
        ev_t keep [$];
        keep = {};
        foreach (evq[i]) begin
            if (evq[i].at <= cyc) expv[evq[i].f] = evq[i].v;
            else keep.push_back(evq[i]);
        end
        evq = keep;
        chk("key", 32'(key_s), expv[F_KEY]);
        chk("run_key", 32'(rk_s), expv[F_RK]);
        chk("busy", 32'(busy_s), expv[F_BUSY]);
        chk("found", 32'(found_s), expv[F_FOUND]);
        chk("exhausted", 32'(exh_s), expv[F_EXH]);
        chk("fail_index", 32'(fail_s), expv[F_FAIL]);
        if (expv[F_ADDR] >= 0) chk("msg_address", 32'(addr_s), expv[F_ADDR]);
        if (rk_s === 1'b1) begin rk_count++; rk_cycles.push_back(cyc); end
        if (found_s === 1'b1 && found_cyc < 0) found_cyc = cyc;
        if (exh_s === 1'b1 && exh_cyc < 0) exh_cyc = cyc;
    end

    task automatic tick(input logic st, input logic ab, input logic rd_force);
        logic rd;
        rd = rd_force | (cyc == done_at);
        search_start = st; search_abort = ab; run_done = rd;
        model_cycle(st, ab, rd);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_log();
        rd_cycles.delete(); rk_cycles.delete();
        rk_count = 0; found_cyc = -1; exh_cyc = -1;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (cyc < m_end + 3 && n < budget) begin tick(1'b0, 1'b0, 1'b0); n++; end
        n_checks++;
        if (n >= budget) begin
            n_errors++;
            $display("FAIL sweep_timeout: got %0d cycles expected under %0d", n, budget);
        end
    endtask

    task automatic sweep(input int s);
        scn = s;
        clear_log();
        tick(1'b1, 1'b0, 1'b0);
        wait_end(2000);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        model_reset();
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 1'b0);

        // Range 10..12 with byte 0 always invalid.
        sel = 1'b1;
        sweep(2);
        chk("exh_run_keys", 32'(rk_count), 3);
        chk("exh_latency", 32'(exh_cyc - rd_cycles[2]), 4);
        chk("exh_flag", 32'(exh_s), 1);
        chk("exh_found", 32'(found_s), 0);
        chk("exh_key", 32'(key_s), 12);

        reset = 1'b0;
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        sel = 1'b0;
        repeat (2) tick(1'b0, 1'b0, 1'b0);

        // First key decrypts to plaintext.
        sweep(0);
        chk("first_run_keys", 32'(rk_count), 1);
        chk("first_found_latency", 32'(found_cyc - rd_cycles[0]), 97);
        chk("first_key", 32'(key_s), 0);
        chk("first_busy", 32'(busy_s), 0);
        chk("first_found", 32'(found_s), 1);

        // Keys 0-2 fail at byte 5, key 3 passes.
        sweep(1);
        chk("rej_run_keys", 32'(rk_count), 4);
        for (int i = 0; i < 3; i++) chk("rej_next_run_key", 32'(rk_cycles[i + 1] - rd_cycles[i]), 19);
        chk("rej_key", 32'(key_s), 3);
        chk("rej_fail_index", 32'(fail_s), 5);
        chk("rej_found", 32'(found_s), 1);

        // Boundary characters at byte 31.
        for (int j = 0; j < 3; j++) begin
            acc_char = (j == 0) ? 8'h61 : ((j == 1) ? 8'h7A : 8'h20);
            sweep(3);
            chk("bound_run_keys", 32'(rk_count), 3);
            chk("bound_key", 32'(key_s), 2);
            chk("bound_fail_index", 32'(fail_s), 31);
            chk("bound_found", 32'(found_s), 1);
        end

        // Spurious start/run_done in RD_WAIT, then abort in CHECK.
        begin
            int r, n;
            scn = 0;
            clear_log();
            tick(1'b1, 1'b0, 1'b0);
            n = 0;
            while (rd_cycles.size() == 0 && n < 100) begin tick(1'b0, 1'b0, 1'b0); n++; end
            r = (rd_cycles.size() > 0) ? rd_cycles[0] : cyc;
            while (cyc < r + 2) tick(1'b0, 1'b0, 1'b0);
            tick(1'b1, 1'b0, 1'b1);
            while (cyc < r + 6) tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b1, 1'b0);
            repeat (20) tick(1'b0, 1'b0, 1'b0);
            chk("abort_run_keys", 32'(rk_count), 1);
            chk("abort_busy", 32'(busy_s), 0);
            chk("abort_found", 32'(found_s), 0);
            chk("abort_exhausted", 32'(exh_s), 0);
        end

        // Reset mid-sweep while key 1 is being scanned.
        begin
            int n;
            scn = 1;
            clear_log();
            tick(1'b1, 1'b0, 1'b0);
            n = 0;
            while (rd_cycles.size() < 2 && n < 200) begin tick(1'b0, 1'b0, 1'b0); n++; end
            repeat (8) tick(1'b0, 1'b0, 1'b0);
            reset = 1'b0;
            model_reset();
            #2;
            chk("rst_key", 32'(key_s), 0);
            chk("rst_busy", 32'(busy_s), 0);
            chk("rst_run_key", 32'(rk_s), 0);
            chk("rst_found", 32'(found_s), 0);
            chk("rst_addr", 32'(addr_s), 0);
            chk("rst_fail_index", 32'(fail_s), 0);
            repeat (3) tick(1'b0, 1'b0, 1'b0);
            reset = 1'b1;
            clear_log();
            repeat (15) tick(1'b0, 1'b0, 1'b0);
            chk("rst_no_run_key", 32'(rk_count), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/key_search_checker.md
# key_search_checker

Key-sweep controller and plaintext validator for the RC4 cracking datapath. It sits downstream of the decrypt core and upstream of the key-schedule and init stages:
- hands each candidate key to the init → scramble → decrypt chain;
- scans the 32-byte decrypted-message RAM once the chain reports completion;
- accepts the key if every byte is lowercase ASCII or space, otherwise advances to the next key until the range is exhausted.

## Interface
Parameters
- MSG_LEN, 32: bytes scanned per candidate
- KEY_WIDTH, 22: candidate key width
- KEY_FIRST, 22'h000000: first key of this instance's range
- KEY_LAST, 22'h3FFFFF: last key of this instance's range (KEY_LAST ≥ KEY_FIRST)

Ports
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; one clock; no other clock domains
- search_start  in  1  one-cycle pulse; begins a sweep at KEY_FIRST
- search_abort  in  1  level; stops any sweep
- key  out  KEY_WIDTH  current candidate, held stable from run_key until the next key decision
- run_key  out  1  one-cycle pulse; the decrypt chain must run with `key`
- run_done  in  1  one-cycle pulse from the chain; decrypted RAM is fully written
- msg_address  out  8  decrypted-RAM read address (upper bits 0)
- msg_q  in  8  decrypted-RAM read data, synchronous RAM
- busy  out  1  high in any state other than IDLE, FOUND, EXHAUSTED
- found  out  1  level; a valid key is on `key`
- exhausted  out  1  level; range failed with no valid key
- fail_index  out  5  index of the last rejected byte (debug/LED)

## Operation
- States: IDLE, LAUNCH, WAIT_RUN, RD_ADDR, RD_WAIT, CHECK, FOUND, EXHAUSTED.
- **IDLE / FOUND / EXHAUSTED**, on search_start:
  - key ← KEY_FIRST; found, exhausted, fail_index ← 0;
  - go to LAUNCH.
- **LAUNCH**: run_key = 1 for exactly this cycle → WAIT_RUN.
- **WAIT_RUN**: wait for run_done. On run_done: byte index k ← 0 → RD_ADDR. run_done seen in any other state is ignored.
- **RD_ADDR, RD_WAIT**: msg_address = k. The RAM has a registered address, so one wait state is required.
- **CHECK**: msg_q is valid if it is in 8'h61–8'h7A, or equals 8'h20.
  - Valid and k < MSG_LEN-1: k++ → RD_ADDR.
  - Valid and k = MSG_LEN-1: → FOUND, found ← 1.
  - Invalid: fail_index ← k.
    - If key = KEY_LAST: → EXHAUSTED, exhausted ← 1, key unchanged.
    - Otherwise: key ← key+1 → LAUNCH.
- Key arithmetic is KEY_WIDTH-bit unsigned. It never wraps, because the KEY_LAST comparison precedes the increment.
- search_start is ignored while busy.
- search_abort, in any state: next state IDLE; found, exhausted, run_key ← 0; key holds its value.
- search_abort takes priority over search_start and run_done in the same cycle.
- Reset mid-sweep behaves like abort, and additionally clears key.

## Timing
- Reset values:
  - state IDLE;
  - key, msg_address, fail_index 0;
  - run_key, busy, found, exhausted 0.
- All outputs are registered except msg_address, which is decoded from k and the state.
- search_start sampled at edge E → run_key high in the cycle after E.
- Cycle numbering: cycle n is the n-th cycle after the edge that samples run_done.
  - Byte k is checked in cycle 3k+3.
  - All bytes valid: found = 1 from cycle 97 (3 × MSG_LEN + 1).
  - Byte k invalid: run_key for the next key is high in cycle 3k+4.
  - Byte k invalid at KEY_LAST: exhausted = 1 from cycle 3k+4.
- found and exhausted hold until search_start, search_abort or reset.
- busy is high from the cycle after search_start until FOUND or EXHAUSTED is entered.

## Structure
- Shared package `key_search_pkg`:
  - state enum;
  - CHAR_LO = 8'h61, CHAR_HI = 8'h7A, CHAR_SPACE = 8'h20;
  - function `is_plain_char(logic [7:0])`;
  - default MSG_LEN and KEY_WIDTH.
- No sub-module: a single FSM plus key register and byte counter. The byte test is the package function.
- The top-level mux arbitrates the decrypted-RAM port between the decrypt core (while WAIT_RUN) and this block (while RD_ADDR/RD_WAIT/CHECK).

## Test plan
- **Reset**: hold reset low mid-sweep → all outputs 0 and state IDLE immediately; no run_key after release until search_start.
- **First key valid**: RAM = "attack at dawn" padded with spaces to 32 bytes; pulse search_start; answer run_done 10 cycles after run_key → exactly one run_key pulse, found = 1 in cycle 97, key = 0, busy = 0.
- **Rejection then acceptance**:
  - Stimulus: byte 5 = 8'h41 for keys 0–2; all bytes valid for key 3.
  - Required: four run_key pulses; each rejection's next run_key in cycle 19; found with key = 3; fail_index = 5.
- **Range exhausted**: KEY_FIRST = 10, KEY_LAST = 12, byte 0 = 8'h00 always → three run_key pulses (keys 10, 11, 12); exhausted = 1 in cycle 4 after the third run_done; found = 0; key = 12.
- **Boundary characters**:
  - 8'h60 and 8'h7B rejected.
  - 8'h61, 8'h7A and 8'h20 at byte 31 accepted.
- **Abort and spurious inputs**:
  - search_start and run_done asserted during RD_WAIT → ignored.
  - search_abort in CHECK → IDLE next cycle, found = exhausted = 0, no further run_key.
